// File: rtl/lpc_initiator.sv
// Host-side LPC initiator: turns single-byte I/O and memory requests into LPC frames.
// Define LPC_ABORT_EN to drive an LFRAME# abort sequence on SYNC timeout or no response.
module lpc_initiator #(
  parameter int unsigned LONG_WAIT_MAX  = 64,
  parameter int unsigned SHORT_WAIT_MAX = 8,
  parameter int unsigned NORESP_MAX     = 3
) (
  input  logic        clk_i,
  input  logic        LRESET,
  input  logic        req_valid_i,
  output logic        req_ready_o,
  input  logic        req_write_i,
  input  logic        req_mem_i,
  input  logic [31:0] req_addr_i,
  input  logic [7:0]  req_data_i,
  output logic        rsp_valid_o,
  output logic [7:0]  rsp_data_o,
  output logic        rsp_err_o,
  output logic        lframe_o,
  output logic [3:0]  lad_o,
  output logic        lad_oe_o,
  input  logic [3:0]  lad_i,
  output logic        busy_o
);

  localparam int unsigned LongW  = $clog2(LONG_WAIT_MAX + 1);
  localparam int unsigned ShortW = $clog2(SHORT_WAIT_MAX + 1);
  localparam int unsigned NrW    = $clog2(NORESP_MAX + 1);

  typedef enum logic [3:0] {
    StIdle, StStart, StCyctype, StAddr, StHdata, StHtar1, StHtar2, StSync,
    StPdata, StPtar1, StPtar2, StResp, StAbort, StAbortEnd
  } state_e;

  state_e            state_q, state_d;
  logic [2:0]        cnt_q, cnt_d;
  logic              write_q, write_d, mem_q, mem_d, err_q, err_d;
  logic [31:0]       addr_q, addr_d;
  logic [7:0]        wdata_q, wdata_d, rdata_q, rdata_d;
  logic [LongW-1:0]  long_q, long_d;
  logic [ShortW-1:0] short_q, short_d;
  logic [NrW-1:0]    nr_q, nr_d;
  logic              lframe_q, lframe_d, oe_q, oe_d, ready_q, ready_d;
  logic [3:0]        lad_q, lad_d;
  logic              rsp_valid_q, rsp_valid_d, rsp_err_q, rsp_err_d;
  logic [7:0]        rsp_data_q, rsp_data_d;
  logic              timeout;
  logic [2:0]        nib_sel;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    write_d = write_q;
    mem_d   = mem_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    err_d   = err_q;
    long_d  = long_q;
    short_d = short_q;
    nr_d    = nr_q;
    timeout = 1'b0;
    case (state_q)
      StIdle: begin
        if (req_valid_i && ready_q) begin
          state_d = StStart;
          write_d = req_write_i;
          mem_d   = req_mem_i;
          addr_d  = req_addr_i;
          wdata_d = req_data_i;
          rdata_d = 8'h00;
          err_d   = 1'b0;
        end
      end
      StStart: state_d = StCyctype;
      StCyctype: begin
        state_d = StAddr;
        cnt_d   = 3'd0;
      end
      StAddr: begin
        if (cnt_q == (mem_q ? 3'd7 : 3'd3)) begin
          state_d = write_q ? StHdata : StHtar1;
          cnt_d   = 3'd0;
        end else begin
          cnt_d = cnt_q + 3'd1;
        end
      end
      StHdata: begin
        if (cnt_q == 3'd1) state_d = StHtar1;
        else cnt_d = cnt_q + 3'd1;
      end
      StHtar1: state_d = StHtar2;
      StHtar2: begin
        state_d = StSync;
        long_d  = '0;
        short_d = '0;
        nr_d    = '0;
      end
      StSync: begin
        // Wait counters only track an unbroken run of the same code.
        long_d  = '0;
        short_d = '0;
        nr_d    = '0;
        case (lad_i)
          4'b0000: begin
            state_d = write_q ? StPtar1 : StPdata;
            cnt_d   = 3'd0;
          end
          4'b0101: begin
            short_d = short_q + ShortW'(1);
            timeout = (short_d == ShortW'(SHORT_WAIT_MAX));
          end
          4'b0110: begin
            long_d  = long_q + LongW'(1);
            timeout = (long_d == LongW'(LONG_WAIT_MAX));
          end
          4'b1111: begin
            nr_d    = nr_q + NrW'(1);
            timeout = (nr_d == NrW'(NORESP_MAX));
          end
          default: begin
            err_d   = 1'b1;
            state_d = StPtar1;
          end
        endcase
        if (timeout) begin
          err_d = 1'b1;
`ifdef LPC_ABORT_EN
          state_d = StAbort;
          cnt_d   = 3'd0;
`else
          state_d = StResp;
`endif
        end
      end
      StPdata: begin
        if (cnt_q == 3'd0) begin
          rdata_d[3:0] = lad_i;
          cnt_d        = 3'd1;
        end else begin
          rdata_d[7:4] = lad_i;
          state_d      = StPtar1;
        end
      end
      StPtar1: state_d = StPtar2;
      StPtar2: state_d = StResp;
      StResp:  state_d = StIdle;
`ifdef LPC_ABORT_EN
      StAbort: begin
        if (cnt_q == 3'd3) state_d = StAbortEnd;
        else cnt_d = cnt_q + 3'd1;
      end
      StAbortEnd: state_d = StResp;
`endif
      default: state_d = StIdle;
    endcase
  end

  // Pin and response values are decoded from the next state so they leave a flop.
  always_comb begin
    lframe_d    = 1'b1;
    oe_d        = 1'b0;
    lad_d       = 4'hF;
    ready_d     = (state_d == StIdle);
    rsp_valid_d = (state_d == StResp);
    rsp_data_d  = rsp_data_q;
    rsp_err_d   = rsp_err_q;
    nib_sel     = mem_d ? (3'd7 - cnt_d) : (3'd3 - cnt_d);
    case (state_d)
      StStart: begin
        lframe_d = 1'b0;
        oe_d     = 1'b1;
        lad_d    = 4'h0;
      end
      StCyctype: begin
        oe_d  = 1'b1;
        lad_d = {1'b0, mem_d, write_d, 1'b0};
      end
      StAddr: begin
        oe_d  = 1'b1;
        lad_d = 4'(addr_d >> {nib_sel, 2'b00});
      end
      StHdata: begin
        oe_d  = 1'b1;
        lad_d = (cnt_d == 3'd0) ? wdata_d[3:0] : wdata_d[7:4];
      end
      StHtar1: oe_d = 1'b1;
      StAbort: begin
        lframe_d = 1'b0;
        oe_d     = 1'b1;
      end
      StResp: begin
        rsp_err_d  = err_d;
        rsp_data_d = (err_d || write_d) ? 8'h00 : rdata_d;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i or negedge LRESET) begin
    if (!LRESET) begin
      state_q     <= StIdle;
      cnt_q       <= 3'd0;
      write_q     <= 1'b0;
      mem_q       <= 1'b0;
      addr_q      <= 32'h0;
      wdata_q     <= 8'h00;
      rdata_q     <= 8'h00;
      err_q       <= 1'b0;
      long_q      <= '0;
      short_q     <= '0;
      nr_q        <= '0;
      lframe_q    <= 1'b1;
      oe_q        <= 1'b0;
      lad_q       <= 4'hF;
      ready_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_err_q   <= 1'b0;
      rsp_data_q  <= 8'h00;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      write_q     <= write_d;
      mem_q       <= mem_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      rdata_q     <= rdata_d;
      err_q       <= err_d;
      long_q      <= long_d;
      short_q     <= short_d;
      nr_q        <= nr_d;
      lframe_q    <= lframe_d;
      oe_q        <= oe_d;
      lad_q       <= lad_d;
      ready_q     <= ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_err_q   <= rsp_err_d;
      rsp_data_q  <= rsp_data_d;
    end
  end

  assign req_ready_o = ready_q;
  assign rsp_valid_o = rsp_valid_q;
  assign rsp_data_o  = rsp_data_q;
  assign rsp_err_o   = rsp_err_q;
  assign lframe_o    = lframe_q;
  assign lad_o       = lad_q;
  assign lad_oe_o    = oe_q;
  assign busy_o      = (state_q != StIdle);

endmodule

// File: tb/tb_lpc_initiator.sv
// Scoreboard bench for lpc_initiator: directed frames, expected responses queued at issue time.
// Build with LPC_ABORT_EN defined to check the abort sequence instead of the direct error path.
module tb_lpc_initiator;

`ifdef LPC_ABORT_EN
  localparam bit AbortEn = 1'b1;
`else
  localparam bit AbortEn = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        LRESET = 1'b1;
  logic        req_valid_i = 1'b0, req_ready_o, req_write_i = 1'b0, req_mem_i = 1'b0;
  logic [31:0] req_addr_i = 32'h0;
  logic [7:0]  req_data_i = 8'h00;
  logic        rsp_valid_o, rsp_err_o, lframe_o, lad_oe_o, busy_o;
  logic [7:0]  rsp_data_o;
  logic [3:0]  lad_o;
  logic [3:0]  lad_i = 4'hF;

  lpc_initiator dut (
    .clk_i       (clk),
    .LRESET      (LRESET),
    .req_valid_i (req_valid_i),
    .req_ready_o (req_ready_o),
    .req_write_i (req_write_i),
    .req_mem_i   (req_mem_i),
    .req_addr_i  (req_addr_i),
    .req_data_i  (req_data_i),
    .rsp_valid_o (rsp_valid_o),
    .rsp_data_o  (rsp_data_o),
    .rsp_err_o   (rsp_err_o),
    .lframe_o    (lframe_o),
    .lad_o       (lad_o),
    .lad_oe_o    (lad_oe_o),
    .lad_i       (lad_i),
    .busy_o      (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [7:0]  data;
    logic        err;
    int          lat;
    logic [79:0] lad;
    int          n;
    int          lf;
  } exp_t;

  exp_t        exp_q[$];
  exp_t        mon_e;
  int          nvec = 0, nfail = 0;
  int          cyc = 0, acc_cyc = 0;
  logic [79:0] lad_log = '0;
  int          lad_n = 0, lf_n = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic check(input string name, input logic [79:0] act, input logic [79:0] exp);
    nvec++;
    if (act !== exp) begin
      nfail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: log driven nibbles and LFRAME# low cycles, compare on each response pulse.
  always @(negedge clk) begin
    if (lad_oe_o) begin
      lad_log = {lad_log[75:0], lad_o};
      lad_n++;
    end
    if (!lframe_o) lf_n++;
    if (rsp_valid_o) begin
      if (exp_q.size() == 0) begin
        nvec++;
        nfail++;
        $display("FAIL unexpected_rsp: got rsp_valid_o at cycle %0d, expected none", cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("rsp_data", 80'(rsp_data_o), 80'(mon_e.data));
        check("rsp_err", 80'(rsp_err_o), 80'(mon_e.err));
        check("latency", 80'(cyc - acc_cyc), 80'(mon_e.lat));
        check("lad_count", 80'(lad_n), 80'(mon_e.n));
        check("lad_seq", lad_log, mon_e.lad);
        check("lframe_low", 80'(lf_n), 80'(mon_e.lf));
      end
    end
  end

  task automatic issue(input logic wr, input logic mem, input logic [31:0] addr,
                       input logic [7:0] wd);
    int k;
    for (k = 0; k < 50; k++) begin
      @(negedge clk);
      if (req_ready_o) break;
    end
    if (k == 50) begin
      nvec++;
      nfail++;
      $display("FAIL ready_wait: got req_ready_o=0 for 50 cycles, expected 1");
    end
    req_write_i = wr;
    req_mem_i   = mem;
    req_addr_i  = addr;
    req_data_i  = wd;
    req_valid_i = 1'b1;
    @(posedge clk);
    #1;
    req_valid_i = 1'b0;
    acc_cyc     = cyc;
    lad_log     = '0;
    lad_n       = 0;
    lf_n        = 0;
  endtask

  // Peripheral: after HTAR2, nwait cycles of wcode, then fcode, then read data if fcode is ready.
  task automatic periph(input int nwait, input logic [3:0] wcode, input logic [3:0] fcode,
                        input logic rd, input logic [7:0] rdata);
    logic prev;
    int   k;
    prev = 1'b0;
    for (k = 0; k < 100; k++) begin
      @(negedge clk);
      if (prev && !lad_oe_o) break;
      prev = lad_oe_o;
    end
    if (k == 100) begin
      nvec++;
      nfail++;
      $display("FAIL htar_wait: got no LAD release in 100 cycles, expected turnaround");
      return;
    end
    @(posedge clk);
    #1;
    for (int i = 0; i < nwait; i++) begin
      lad_i = wcode;
      @(posedge clk);
      #1;
    end
    lad_i = fcode;
    @(posedge clk);
    #1;
    if (rd && fcode == 4'h0) begin
      lad_i = rdata[3:0];
      @(posedge clk);
      #1;
      lad_i = rdata[7:4];
      @(posedge clk);
      #1;
    end
    lad_i = 4'hF;
  endtask

  task automatic run(input logic wr, input logic mem, input logic [31:0] addr,
                     input logic [7:0] wd, input logic use_p, input int nwait,
                     input logic [3:0] wcode, input logic [3:0] fcode, input logic [7:0] rdata,
                     input logic [7:0] e_data, input logic e_err, input int e_lat,
                     input logic [79:0] e_lad, input int e_n, input int e_lf,
                     input logic aborts);
    exp_t e;
    int   k;
    e.data = e_data;
    e.err  = e_err;
    e.lat  = e_lat;
    e.lad  = e_lad;
    e.n    = e_n;
    e.lf   = e_lf;
    if (aborts && AbortEn) begin
      e.lat = e_lat + 5;
      e.lad = {e_lad[63:0], 16'hFFFF};
      e.n   = e_n + 4;
      e.lf  = e_lf + 4;
    end
    exp_q.push_back(e);
    issue(wr, mem, addr, wd);
    fork
      begin
        if (use_p) periph(nwait, wcode, fcode, !wr, rdata);
      end
      begin
        for (k = 0; k < 300; k++) begin
          @(negedge clk);
          if (exp_q.size() == 0) break;
        end
        if (k == 300) begin
          nvec++;
          nfail++;
          $display("FAIL rsp_wait: got no rsp_valid_o in 300 cycles, expected a response");
          exp_q.delete();
        end
      end
    join
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_lframe"}, 80'(lframe_o), 80'(1'b1));
    check({tag, "_oe"}, 80'(lad_oe_o), 80'(1'b0));
    check({tag, "_lad"}, 80'(lad_o), 80'(4'hF));
    check({tag, "_ready"}, 80'(req_ready_o), 80'(1'b0));
    check({tag, "_busy"}, 80'(busy_o), 80'(1'b0));
    check({tag, "_rsp_valid"}, 80'(rsp_valid_o), 80'(1'b0));
    check({tag, "_rsp_err"}, 80'(rsp_err_o), 80'(1'b0));
    check({tag, "_rsp_data"}, 80'(rsp_data_o), 80'(8'h00));
  endtask

  initial begin
    #2 LRESET = 1'b0;
    #1 check_reset_outputs("reset");
    repeat (2) @(negedge clk);
    check("ready_in_reset", 80'(req_ready_o), 80'(1'b0));
    LRESET = 1'b1;
    @(posedge clk);
    #1 check("ready_after_release", 80'(req_ready_o), 80'(1'b1));

    // wr mem addr data | periph nwait wcode fcode rdata | data err lat lad n lf aborts
    run(1, 0, 32'h0000_F0F0, 8'h5A, 1, 0, 4'h0, 4'h0, 8'h00,
        8'h00, 0, 13, 80'h02F0F0A5F, 9, 1, 0);
    run(0, 0, 32'h0000_9696, 8'h00, 1, 10, 4'h6, 4'h0, 8'hA5,
        8'hA5, 0, 23, 80'h009696F, 7, 1, 0);
    run(1, 1, 32'h1234_5678, 8'hBB, 1, 0, 4'h0, 4'h0, 8'h00,
        8'h00, 0, 17, 80'h0612345678BBF, 13, 1, 0);
    run(0, 1, 32'h000F_00C1, 8'h00, 1, 3, 4'h5, 4'h0, 8'h3C,
        8'h3C, 0, 20, 80'h04000F00C1F, 11, 1, 0);
    run(0, 0, 32'h0000_0080, 8'h00, 0, 0, 4'h0, 4'h0, 8'h00,
        8'h00, 1, 11, 80'h000080F, 7, 1, 1);
    run(1, 0, 32'h0000_0002, 8'h77, 1, 0, 4'h0, 4'hA, 8'h00,
        8'h00, 1, 13, 80'h02000277F, 9, 1, 0);
    run(0, 0, 32'h0000_0011, 8'h00, 1, 0, 4'h0, 4'h3, 8'h99,
        8'h00, 1, 11, 80'h000011F, 7, 1, 0);
    run(0, 0, 32'h0000_0000, 8'h00, 1, 63, 4'h6, 4'h0, 8'h42,
        8'h42, 0, 76, 80'h000000F, 7, 1, 0);
    run(0, 0, 32'h0000_0000, 8'h00, 1, 70, 4'h6, 4'hF, 8'h00,
        8'h00, 1, 72, 80'h000000F, 7, 1, 1);
    run(1, 1, 32'h0000_0010, 8'h01, 1, 7, 4'h5, 4'h0, 8'h00,
        8'h00, 0, 24, 80'h060000001010F, 13, 1, 0);
    run(1, 1, 32'h0000_0010, 8'h01, 1, 20, 4'h5, 4'hF, 8'h00,
        8'h00, 1, 22, 80'h060000001010F, 13, 1, 1);
    // Leave a nonzero rsp_data_o behind so the reset clear is visible.
    run(0, 0, 32'h0000_1234, 8'h00, 1, 0, 4'h0, 4'h0, 8'h6E,
        8'h6E, 0, 13, 80'h001234F, 7, 1, 0);

    // Reset in the middle of an MR address phase: no response may follow.
    issue(0, 1, 32'hDEAD_BEEF, 8'h00);
    @(posedge clk);
    @(posedge clk);
    #1 check("mid_busy", 80'(busy_o), 80'(1'b1));
    check("mid_oe", 80'(lad_oe_o), 80'(1'b1));
    #2 LRESET = 1'b0;
    #1 check_reset_outputs("mid_reset");
    repeat (2) @(negedge clk);
    LRESET = 1'b1;
    @(posedge clk);
    #1 check("mid_ready_after_release", 80'(req_ready_o), 80'(1'b1));
    run(1, 0, 32'h0000_0380, 8'hC3, 1, 0, 4'h0, 4'h0, 8'h00,
        8'h00, 0, 13, 80'h0203803CF, 9, 1, 0);

    repeat (5) @(negedge clk);
    check("final_idle", 80'(busy_o), 80'(1'b0));
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nfail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/lpc_initiator.md
Name: lpc_initiator

Overview:
- Host-side LPC bus initiator. Turns single-byte I/O and memory read/write requests from a local valid/ready port into LPC frames, and returns read data or error status.
- It is the counterpart to lpc_periph: it drives START/CYCTYPE/ADDR/data/TAR, then samples SYNC and read data driven back by the peripheral.
- Sits between the controller/GPIO logic and the LPC pins. Tristate is split into lad_o/lad_oe_o/lad_i for the top-level pad.

Parameters:
- LONG_WAIT_MAX, 64: max consecutive long-wait SYNC (0110) cycles before timeout.
- SHORT_WAIT_MAX, 8: max consecutive short-wait SYNC (0101) cycles before timeout.
- NORESP_MAX, 3: consecutive SYNC=1111 cycles treated as no peripheral present.

Ports:
- clk_i  in  1  LPC clock (LCLK domain).
- LRESET  in  1  asynchronous reset, active-low.
- req_valid_i  in  1  request valid.
- req_ready_o  out  1  initiator can accept a request.
- req_write_i  in  1  1 = write, 0 = read.
- req_mem_i  in  1  1 = memory cycle, 0 = I/O cycle.
- req_addr_i  in  32  address; I/O cycles use [15:0].
- req_data_i  in  8  write data.
- rsp_valid_o  out  1  one-cycle pulse: cycle complete.
- rsp_data_o  out  8  read data; 0x00 for writes or on error.
- rsp_err_o  out  1  qualified by rsp_valid_o; SYNC error, timeout or no response.
- lframe_o  out  1  LFRAME#, active-low.
- lad_o  out  4  LAD drive value.
- lad_oe_o  out  1  LAD output enable.
- lad_i  in  4  LAD sampled value.
- busy_o  out  1  FSM not in IDLE.

Behaviour:
- Reset (LRESET low, async):
  - state IDLE; lframe_o=1, lad_o=4'hF, lad_oe_o=0.
  - req_ready_o=0 while reset is asserted; it goes to 1 on the first clock after release.
  - rsp_valid_o=0, rsp_err_o=0, rsp_data_o=0, busy_o=0, all counters 0.
- Reset mid-frame: immediate return to IDLE with reset values. No response pulse for the in-flight request.
- Accept: req_ready_o=1 only in IDLE. Handshake completes when req_valid_i&req_ready_o on a rising edge; all request fields are registered then. Next cycle is START.
- States and drive values; all outputs are registered and change on the rising edge:
  - START: lframe_o=0, lad_oe_o=1, lad_o=0000.
  - CYCTYPE: lframe_o=1; lad_o = {0, mem, write, 0}, i.e. IOR 0000, IOW 0010, MR 0100, MW 0110.
  - ADDR: nibbles MSB first. 4 cycles for I/O (addr[15:12] first), 8 for memory (addr[31:28] first).
  - HDATA (writes only): 2 cycles, data[3:0] then data[7:4].
  - HTAR1: lad_o=1111, oe=1. HTAR2: oe=0.
  - SYNC: oe=0; lad_i sampled each cycle.
    - 0000: reads go to PDATA, writes go to PTAR1.
    - 0101: short wait. 0110: long wait. Each has its own counter, reset when the code changes.
    - 1010: error; go to PTAR1 with err=1, and for reads skip PDATA.
    - 1111: increments the no-response counter.
    - Any other code is treated as 1010.
    - Limit: counter reaching its MAX (the MAX-th consecutive cycle) triggers a timeout (see Optional Feature).
  - PDATA: 2 cycles; capture lad_i into data[3:0] then data[7:4].
  - PTAR1, PTAR2: oe=0; the peripheral owns these cycles.
  - After PTAR2: rsp_valid_o=1 for one cycle together with rsp_data_o/rsp_err_o; state returns to IDLE.
- req_ready_o rises in the cycle after the rsp_valid_o pulse, so back-to-back frames have one idle cycle between them.
- Latency, accept edge to rsp_valid_o with zero-wait SYNC (N wait cycles add N):
  - IOW and IOR: 13 cycles.
  - MW and MR: 17 cycles.
- rsp_data_o holds its value until the next response.

Optional Feature:
- Macro: LPC_ABORT_EN.
- Defined: on timeout or no-response, FSM enters ABORT. lframe_o=0, lad_oe_o=1, lad_o=1111 for exactly 4 cycles, then one cycle with lframe_o=1 and oe=0. It then pulses rsp_valid_o with rsp_err_o=1 and returns to IDLE.
- Undefined: on timeout or no-response, FSM skips ABORT. It goes directly to the rsp_valid_o pulse with rsp_err_o=1, then IDLE, with LAD undriven throughout.
- SYNC error (1010) is never aborted; it always completes the normal PTAR sequence.

Test Plan:
- IOW addr 0xF0F0, data 0x5A, peripheral SYNC 0000 immediately:
  - LAD = 0000, 0010, F, 0, F, 0, A, 5, F, then release.
  - rsp_valid_o 13 cycles after accept, err=0.
- IOR addr 0x9696, 10 long-wait cycles then 0000 with data 0xA5:
  - peripheral drives 5 then A; rsp_data_o=0xA5, err=0.
  - rsp_valid_o at 23 cycles.
- MW addr 0x1234_5678, data 0xBB:
  - CYCTYPE 0110, 8 address nibbles 1..8, then B, B; rsp_valid_o at 17 cycles.
- No peripheral (lad_i=1111 constant), IOR:
  - with LPC_ABORT_EN: lframe_o low 4 cycles with LAD=1111, then rsp_err_o=1.
  - without it: rsp_err_o=1 and lframe_o stays high.
- SYNC 1010 on IOW: PTAR completes, rsp_err_o=1, rsp_data_o=0x00, no abort.
- LRESET asserted during the ADDR state of an MR:
  - outputs return to reset values asynchronously with no rsp pulse.
  - after release, a new IOW completes normally.
